// File: rtl/game_pkg.sv
// Shared types and constants for the binary number game.
// Widths, LFSR taps and the round controller state set.
package game_pkg;

  localparam int TARGET_W = 8;
  localparam int TIME_W   = 5;
  localparam int CNT_W    = 4;

  // Feedback taps 8,6,5,4 of a left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    RESULT,
    DONE
  } state_t;

endpackage

// File: rtl/round_controller_if.sv
// Game-side bundle: buttons, switches, timer link and display.
// master = round controller, slave = surrounding top level.
interface round_controller_if;
  import game_pkg::*;

  logic                start;
  logic                submit;
  logic [TARGET_W-1:0] answer;
  logic                timer_set_f;
  logic [TIME_W-1:0]   timer_set_v;
  logic [TIME_W-1:0]   timer_timeleft;
  logic                timer_end_f;
  logic [TARGET_W-1:0] target;
  logic [7:0]          score;
  logic [CNT_W-1:0]    round;
  logic [CNT_W-1:0]    misses;
  logic                hit_p;
  logic                miss_p;
  logic                busy;
  logic                game_over;

  modport master (
    input  start, submit, answer,
    input  timer_timeleft, timer_end_f,
    output timer_set_f, timer_set_v,
    output target, score, round, misses,
    output hit_p, miss_p, busy, game_over
  );

  modport slave (
    output start, submit, answer,
    output timer_timeleft, timer_end_f,
    input  timer_set_f, timer_set_v,
    input  target, score, round, misses,
    input  hit_p, miss_p, busy, game_over
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as target source.
// A nonzero seed keeps it on the 255-state cycle.
module lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  // Shift left, feeding back the parity of the tapped bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/round_controller.sv
// Sequences one game: draw target, load timer, judge submit.
// Scores hits by remaining time, ends on round or miss limit.
module round_controller
  import game_pkg::*;
#(
  parameter int         ROUNDS      = 8,
  parameter int         MAX_MISS    = 3,
  parameter int         START_TIME  = 20,
  parameter int         TIME_STEP   = 2,
  parameter int         MIN_TIME    = 5,
  parameter int         RESULT_HOLD = 4,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  round_controller_if.master bus
);

  localparam int HOLD_W =
    (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RESULT_HOLD - 1);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] MISS_C   = CNT_W'(MAX_MISS);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [7:0]          lfsr_q;

  logic [CNT_W-1:0]    ld_round;
  logic [8:0]          dec;
  logic [8:0]          rem;
  logic [TIME_W-1:0]   budget;
  logic [9:0]          sum;
  logic [7:0]          sat;
  logic                is_hit;
  logic                last;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Time budget for the next load, hit score, end-of-game test.
  always_comb begin
    ld_round = bus.round;
    if (state == IDLE || state == DONE) ld_round = '0;
    dec = 9'(ld_round) * 9'(TIME_STEP);
    rem = '0;
    if (9'(START_TIME) > dec) rem = 9'(START_TIME) - dec;
    budget = TIME_W'((rem < 9'(MIN_TIME)) ? 9'(MIN_TIME) : rem);
    sum = 10'(bus.score) + 10'(bus.timer_timeleft) + 10'd1;
    sat = (sum > 10'd255) ? 8'hFF : sum[7:0];
    is_hit = (bus.answer == bus.target);
    last = (bus.round == ROUNDS_C) || (bus.misses == MISS_C);
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      bus.timer_set_f <= 1'b0;
      bus.timer_set_v <= '0;
      bus.target      <= '0;
      bus.score       <= '0;
      bus.round       <= '0;
      bus.misses      <= '0;
      bus.hit_p       <= 1'b0;
      bus.miss_p      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.game_over   <= 1'b0;
    end else begin
      bus.timer_set_f <= 1'b0;
      bus.hit_p       <= 1'b0;
      bus.miss_p      <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.score       <= '0;
            bus.round       <= '0;
            bus.misses      <= '0;
            bus.game_over   <= 1'b0;
            bus.busy        <= 1'b1;
            bus.timer_set_f <= 1'b1;
            bus.timer_set_v <= budget;
            state           <= LOAD;
          end
        end
        LOAD: begin
          bus.target <= lfsr_q;
          state      <= ARM;
        end
        ARM: begin
          state <= RUN;
        end
        RUN: begin
          unique case (1'b1)
            bus.submit && is_hit: begin
              bus.score <= sat;
              bus.hit_p <= 1'b1;
              bus.round <= bus.round + 1'b1;
              state     <= RESULT;
            end
            bus.submit && !is_hit: begin
              bus.misses <= bus.misses + 1'b1;
              bus.miss_p <= 1'b1;
              bus.round  <= bus.round + 1'b1;
              state      <= RESULT;
            end
            !bus.submit && bus.timer_end_f: begin
              bus.misses <= bus.misses + 1'b1;
              bus.miss_p <= 1'b1;
              bus.round  <= bus.round + 1'b1;
              state      <= RESULT;
            end
            default: ;
          endcase
        end
        RESULT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (last) begin
              bus.busy      <= 1'b0;
              bus.game_over <= 1'b1;
              state         <= DONE;
            end else begin
              bus.timer_set_f <= 1'b1;
              bus.timer_set_v <= budget;
              state           <= LOAD;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed + randomized bench for round_controller.
// Two instances: default budget and a short START_TIME=8 game.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       submit;
  logic [7:0] answer;
  logic [4:0] tl;
  logic       end_f;
  int         sel;

  int n_chk  = 0;
  int n_fail = 0;

  int m_score;
  int m_round;
  int m_miss;
  bit m_done;
  bit have_prev;
  logic [7:0] prev_tgt;

  always #5 clk = ~clk;

  round_controller_if b0 ();
  round_controller_if b1 ();

  assign b0.start          = start & (sel == 0);
  assign b0.submit         = submit & (sel == 0);
  assign b0.answer         = answer;
  assign b0.timer_timeleft = tl;
  assign b0.timer_end_f    = end_f & (sel == 0);
  assign b1.start          = start & (sel == 1);
  assign b1.submit         = submit & (sel == 1);
  assign b1.answer         = answer;
  assign b1.timer_timeleft = tl;
  assign b1.timer_end_f    = end_f & (sel == 1);

  round_controller u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  round_controller #(
    .START_TIME (8),
    .TIME_STEP  (2),
    .MIN_TIME   (5)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  logic       o_set_f;
  logic [4:0] o_set_v;
  logic [7:0] o_target;
  logic [7:0] o_score;
  logic [3:0] o_round;
  logic [3:0] o_misses;
  logic       o_hit;
  logic       o_miss;
  logic       o_busy;
  logic       o_over;

  always_comb begin
    o_set_f  = sel ? b1.timer_set_f : b0.timer_set_f;
    o_set_v  = sel ? b1.timer_set_v : b0.timer_set_v;
    o_target = sel ? b1.target      : b0.target;
    o_score  = sel ? b1.score       : b0.score;
    o_round  = sel ? b1.round       : b0.round;
    o_misses = sel ? b1.misses      : b0.misses;
    o_hit    = sel ? b1.hit_p       : b0.hit_p;
    o_miss   = sel ? b1.miss_p      : b0.miss_p;
    o_busy   = sel ? b1.busy        : b0.busy;
    o_over   = sel ? b1.game_over   : b0.game_over;
  end

  function automatic int budget(int r, int st);
    int b;
    b = st - r * 2;
    if (b < 0) b = 0;
    if (b < 5) b = 5;
    return b;
  endfunction

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".set_f"},  o_set_f,  0);
    chk({tag, ".set_v"},  o_set_v,  0);
    chk({tag, ".target"}, o_target, 0);
    chk({tag, ".score"},  o_score,  0);
    chk({tag, ".round"},  o_round,  0);
    chk({tag, ".misses"}, o_misses, 0);
    chk({tag, ".hit_p"},  o_hit,    0);
    chk({tag, ".miss_p"}, o_miss,   0);
    chk({tag, ".busy"},   o_busy,   0);
    chk({tag, ".over"},   o_over,   0);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score   = 0;
    m_round   = 0;
    m_miss    = 0;
    m_done    = 1'b0;
    have_prev = 1'b0;
    chk("start.score",  o_score,  0);
    chk("start.round",  o_round,  0);
    chk("start.misses", o_misses, 0);
    chk("start.over",   o_over,   0);
  endtask

  // Entered in the LOAD cycle, leaves in the first RUN cycle.
  task automatic to_run(input bit noise);
    chk("load.set_f", o_set_f, 1);
    chk("load.set_v", o_set_v,
        budget(m_round, sel ? 8 : 20));
    chk("load.busy", o_busy, 1);
    tick();
    chk("arm.set_f", o_set_f, 0);
    if (noise) begin
      end_f  = 1'b1;
      submit = 1'b1;
      answer = ~o_target;
    end
    tick();
    end_f  = 1'b0;
    submit = 1'b0;
    chk("run.round",  o_round,  m_round);
    chk("run.misses", o_misses, m_miss);
    chk("run.tgt_nz", int'(o_target != 8'd0), 1);
    if (have_prev)
      chk("run.tgt_new", int'(o_target != prev_tgt), 1);
    prev_tgt  = o_target;
    have_prev = 1'b1;
  endtask

  // kind: 0 hit, 1 wrong, 2 timeout, 3 hit with timeout.
  task automatic resolve(input int kind, input int tlv);
    bit hit;
    hit = (kind == 0) || (kind == 3);
    tl  = 5'(tlv);
    case (kind)
      0: begin submit = 1'b1; answer = o_target; end
      1: begin
        submit = 1'b1;
        answer = o_target ^ 8'($urandom_range(1, 255));
      end
      2: end_f = 1'b1;
      default: begin
        submit = 1'b1;
        end_f  = 1'b1;
        answer = o_target;
      end
    endcase
    if (hit) begin
      m_score = m_score + 1 + tlv;
      if (m_score > 255) m_score = 255;
    end else begin
      m_miss++;
    end
    m_round++;
    m_done = (m_round == 8) || (m_miss == 3);
    tick();
    submit = 1'b0;
    end_f  = 1'b0;
    chk("res.score",  o_score,  m_score);
    chk("res.round",  o_round,  m_round);
    chk("res.misses", o_misses, m_miss);
    chk("res.hit_p",  o_hit,    int'(hit));
    chk("res.miss_p", o_miss,   int'(!hit));
    chk("res.busy",   o_busy,   1);
    tick();
    chk("res.hit_off",  o_hit,  0);
    chk("res.miss_off", o_miss, 0);
    tick();
    tick();
    tick();
    chk("post.set_f", o_set_f, int'(!m_done));
    chk("post.over",  o_over,  int'(m_done));
    chk("post.busy",  o_busy,  int'(!m_done));
  endtask

  initial begin
    sel    = 0;
    start  = 1'b0;
    submit = 1'b0;
    answer = 8'd0;
    tl     = 5'd0;
    end_f  = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    chk_reset("por");
    rst_n = 1'b1;
    tick();

    // Two hits, then reset in the middle of round 2.
    start_game();
    to_run(1'b0);
    resolve(0, 12);
    to_run(1'b0);
    resolve(0, 3);
    to_run(1'b0);
    chk("pre_rst.score", o_score, 17);
    chk("pre_rst.round", o_round, 2);
    rst_n = 1'b0;
    #1;
    chk_reset("midrun");
    tick();
    rst_n = 1'b1;
    tick();

    // Wrong then hit with timeout on the same edge, then random.
    start_game();
    to_run(1'b0);
    resolve(1, $urandom_range(0, 31));
    to_run(1'b1);
    resolve(3, $urandom_range(0, 31));
    while (!m_done) begin
      to_run(1'($urandom_range(0, 1)));
      resolve($urandom_range(0, 3), $urandom_range(0, 31));
    end

    // Timeouts every round: budgets 20, 18, 16.
    start_game();
    for (int i = 0; i < 3; i++) begin
      to_run(1'b0);
      resolve(2, 0);
    end
    chk("to.round", o_round, 3);
    chk("to.over",  o_over,  1);

    // Short game: budgets 8, 6, 5, 5, ...
    sel = 1;
    start_game();
    for (int i = 0; i < 8; i++) begin
      to_run(1'b0);
      resolve(0, $urandom_range(0, 31));
    end
    chk("short.round", o_round, 8);
    chk("short.over",  o_over,  1);

    // Restart from DONE, large timeleft saturates score.
    start_game();
    for (int i = 0; i < 8; i++) begin
      to_run(1'b0);
      resolve(0, 31);
    end
    chk("sat.score", o_score, 255);
    chk("sat.over",  o_over,  1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
